// File: rtl/cv32e40x_pkg.sv
// Shared types for the EX-stage sequential divider.
package cv32e40x_pkg;

  localparam int unsigned DIV_W   = 32;
  localparam int unsigned DIV_CNT = 5;

  typedef enum logic [1:0] {
    DIV_DIV  = 2'b00,
    DIV_DIVU = 2'b01,
    DIV_REM  = 2'b10,
    DIV_REMU = 2'b11
  } div_opcode_e;

  typedef enum logic [2:0] {
    DIV_IDLE   = 3'd0,
    DIV_CLZ    = 3'd1,
    DIV_SHIFT  = 3'd2,
    DIV_DIVIDE = 3'd3,
    DIV_FINISH = 3'd4
  } div_state_e;

endpackage

// File: rtl/cv32e40x_div_seq.sv
// Iterative restoring divider that borrows the ALU's CLZ and barrel shifter
// to normalise the divisor, producing one quotient bit per cycle.
module cv32e40x_div_seq
  import cv32e40x_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               valid_i,
  output logic               ready_o,
  input  div_opcode_e        operator_i,
  input  logic [DIV_W-1:0]   op_a_i,
  input  logic [DIV_W-1:0]   op_b_i,
  input  logic               kill_i,
  output logic               valid_o,
  input  logic               ready_i,
  output logic [DIV_W-1:0]   result_o,
  output logic               alu_clz_en_o,
  output logic [DIV_W-1:0]   alu_clz_data_o,
  input  logic [5:0]         alu_clz_result_i,
  output logic               alu_shift_en_o,
  output logic [5:0]         alu_shift_amt_o,
  output logic [DIV_W-1:0]   alu_op_a_o,
  input  logic [DIV_W-1:0]   alu_op_a_shifted_i
);

  div_state_e           state_q, state_d;
  div_opcode_e          op_q, op_d;
  logic [DIV_W-1:0]     abs_a_q, abs_a_d;
  logic [DIV_W-1:0]     abs_b_q, abs_b_d;
  logic [DIV_W-1:0]     raw_a_q, raw_a_d;
  logic                 sign_a_q, sign_a_d;
  logic                 sign_b_q, sign_b_d;
  logic [DIV_CNT-1:0]   cnt_q, cnt_d;
  logic [DIV_W-1:0]     divisor_q, divisor_d;
  logic [DIV_W-1:0]     rem_q, rem_d;
  logic [DIV_W-1:0]     quot_q, quot_d;
  logic                 valid_q, valid_d;
  logic [DIV_W-1:0]     result_q, result_d;
  logic                 clz_en_q, clz_en_d;
  logic [DIV_W-1:0]     clz_data_q, clz_data_d;
  logic                 shift_en_q, shift_en_d;
  logic [5:0]           shift_amt_q, shift_amt_d;
  logic [DIV_W-1:0]     alu_op_a_q, alu_op_a_d;

  logic                 signed_op;
  logic                 in_sign_a;
  logic                 in_sign_b;
  logic                 b_nonzero;
  logic [DIV_W-1:0]     quot_fin;
  logic [DIV_W-1:0]     rem_fin;
  logic [DIV_W-1:0]     fin_result;

  assign signed_op = (operator_i == DIV_DIV) || (operator_i == DIV_REM);
  assign in_sign_a = signed_op & op_a_i[DIV_W-1];
  assign in_sign_b = signed_op & op_b_i[DIV_W-1];

  // Final sign fix-up; a zero divisor leaves both results untouched.
  assign b_nonzero  = (abs_b_q != '0);
  assign quot_fin   = ((sign_a_q ^ sign_b_q) && b_nonzero) ? (~quot_q + 32'd1) : quot_q;
  assign rem_fin    = (sign_a_q && b_nonzero) ? (~rem_q + 32'd1) : rem_q;
  assign fin_result = ((op_q == DIV_REM) || (op_q == DIV_REMU)) ? rem_fin : quot_fin;

  assign ready_o         = (state_q == DIV_IDLE);
  assign valid_o         = valid_q;
  assign result_o        = result_q;
  assign alu_clz_en_o    = clz_en_q;
  assign alu_clz_data_o  = clz_data_q;
  assign alu_shift_en_o  = shift_en_q;
  assign alu_shift_amt_o = shift_amt_q;
  assign alu_op_a_o      = alu_op_a_q;

  // Next-state and datapath update.
  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    abs_a_d     = abs_a_q;
    abs_b_d     = abs_b_q;
    raw_a_d     = raw_a_q;
    sign_a_d    = sign_a_q;
    sign_b_d    = sign_b_q;
    cnt_d       = cnt_q;
    divisor_d   = divisor_q;
    rem_d       = rem_q;
    quot_d      = quot_q;
    valid_d     = valid_q;
    result_d    = result_q;
    clz_en_d    = 1'b0;
    clz_data_d  = '0;
    shift_en_d  = 1'b0;
    shift_amt_d = '0;
    alu_op_a_d  = '0;

    case (state_q)
      DIV_IDLE: begin
        if (valid_i && !kill_i) begin
          op_d     = operator_i;
          raw_a_d  = op_a_i;
          sign_a_d = in_sign_a;
          sign_b_d = in_sign_b;
          abs_a_d  = in_sign_a ? (~op_a_i + 32'd1) : op_a_i;
          abs_b_d  = in_sign_b ? (~op_b_i + 32'd1) : op_b_i;
          state_d  = DIV_CLZ;
        end
      end
      DIV_CLZ: begin
        if (alu_clz_result_i == 6'd32) begin
          quot_d  = '1;
          rem_d   = raw_a_q;
          state_d = DIV_FINISH;
        end else begin
          cnt_d   = alu_clz_result_i[DIV_CNT-1:0];
          state_d = DIV_SHIFT;
        end
      end
      DIV_SHIFT: begin
        divisor_d = alu_op_a_shifted_i;
        rem_d     = abs_a_q;
        quot_d    = '0;
        state_d   = DIV_DIVIDE;
      end
      DIV_DIVIDE: begin
        if (rem_q >= divisor_q) begin
          rem_d  = rem_q - divisor_q;
          quot_d = {quot_q[DIV_W-2:0], 1'b1};
        end else begin
          quot_d = {quot_q[DIV_W-2:0], 1'b0};
        end
        divisor_d = divisor_q >> 1;
        if (cnt_q == '0) begin
          state_d = DIV_FINISH;
        end else begin
          cnt_d = cnt_q - 5'd1;
        end
      end
      DIV_FINISH: begin
        // First FINISH cycle latches the result; it is then held until taken.
        if (!valid_q) begin
          valid_d  = 1'b1;
          result_d = fin_result;
        end else if (ready_i) begin
          valid_d = 1'b0;
          state_d = DIV_IDLE;
        end
      end
      default: state_d = DIV_IDLE;
    endcase

    if (kill_i) begin
      state_d = DIV_IDLE;
      valid_d = 1'b0;
    end

    // ALU claim signals are registered so they line up with the state they belong to.
    clz_en_d    = (state_d == DIV_CLZ);
    clz_data_d  = clz_en_d ? abs_b_d : '0;
    shift_en_d  = (state_d == DIV_SHIFT);
    shift_amt_d = shift_en_d ? {1'b0, cnt_d} : 6'd0;
    alu_op_a_d  = shift_en_d ? abs_b_q : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= DIV_IDLE;
      op_q        <= DIV_DIV;
      abs_a_q     <= '0;
      abs_b_q     <= '0;
      raw_a_q     <= '0;
      sign_a_q    <= 1'b0;
      sign_b_q    <= 1'b0;
      cnt_q       <= '0;
      divisor_q   <= '0;
      rem_q       <= '0;
      quot_q      <= '0;
      valid_q     <= 1'b0;
      result_q    <= '0;
      clz_en_q    <= 1'b0;
      clz_data_q  <= '0;
      shift_en_q  <= 1'b0;
      shift_amt_q <= '0;
      alu_op_a_q  <= '0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      abs_a_q     <= abs_a_d;
      abs_b_q     <= abs_b_d;
      raw_a_q     <= raw_a_d;
      sign_a_q    <= sign_a_d;
      sign_b_q    <= sign_b_d;
      cnt_q       <= cnt_d;
      divisor_q   <= divisor_d;
      rem_q       <= rem_d;
      quot_q      <= quot_d;
      valid_q     <= valid_d;
      result_q    <= result_d;
      clz_en_q    <= clz_en_d;
      clz_data_q  <= clz_data_d;
      shift_en_q  <= shift_en_d;
      shift_amt_q <= shift_amt_d;
      alu_op_a_q  <= alu_op_a_d;
    end
  end

endmodule

// File: tb/tb_cv32e40x_div_seq.sv
// Directed bench for cv32e40x_div_seq with a behavioural ALU CLZ/shifter.
module tb_cv32e40x_div_seq;
  import cv32e40x_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        valid_i;
  logic        ready_o;
  div_opcode_e operator_i;
  logic [31:0] op_a_i;
  logic [31:0] op_b_i;
  logic        kill_i;
  logic        valid_o;
  logic        ready_i;
  logic [31:0] result_o;
  logic        alu_clz_en_o;
  logic [31:0] alu_clz_data_o;
  logic [5:0]  alu_clz_result_i;
  logic        alu_shift_en_o;
  logic [5:0]  alu_shift_amt_o;
  logic [31:0] alu_op_a_o;
  logic [31:0] alu_op_a_shifted_i;

  int n_chk = 0;
  int n_bad = 0;

  cv32e40x_div_seq dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .valid_i            (valid_i),
    .ready_o            (ready_o),
    .operator_i         (operator_i),
    .op_a_i             (op_a_i),
    .op_b_i             (op_b_i),
    .kill_i             (kill_i),
    .valid_o            (valid_o),
    .ready_i            (ready_i),
    .result_o           (result_o),
    .alu_clz_en_o       (alu_clz_en_o),
    .alu_clz_data_o     (alu_clz_data_o),
    .alu_clz_result_i   (alu_clz_result_i),
    .alu_shift_en_o     (alu_shift_en_o),
    .alu_shift_amt_o    (alu_shift_amt_o),
    .alu_op_a_o         (alu_op_a_o),
    .alu_op_a_shifted_i (alu_op_a_shifted_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [5:0] clz32(input logic [31:0] x);
    for (int i = 31; i >= 0; i--) begin
      if (x[i]) return 6'(31 - i);
    end
    return 6'd32;
  endfunction

  // Stand-in for the ALU resources the divider borrows.
  assign alu_clz_result_i   = clz32(alu_clz_data_o);
  assign alu_op_a_shifted_i = alu_op_a_o << alu_shift_amt_o[4:0];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Issue one operation from IDLE and wait for valid_o; leaves the result un-acknowledged.
  task automatic issue(input string tag, input div_opcode_e op, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] exp, input int exp_lat);
    int lat;
    check_eq({tag, "_rdy"}, 32'(ready_o), 32'd1);
    operator_i = op;
    op_a_i     = a;
    op_b_i     = b;
    valid_i    = 1'b1;
    @(posedge clk); #1;
    valid_i = 1'b0;
    lat = 0;
    while (!valid_o && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    check_eq({tag, "_valid"}, 32'(valid_o), 32'd1);
    check_eq({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    check_eq({tag, "_res"}, result_o, exp);
  endtask

  task automatic handshake(input string tag);
    ready_i = 1'b1;
    @(posedge clk); #1;
    check_eq({tag, "_vdrop"}, 32'(valid_o), 32'd0);
    check_eq({tag, "_idle"}, 32'(ready_o), 32'd1);
  endtask

  task automatic run(input string tag, input div_opcode_e op, input logic [31:0] a,
                     input logic [31:0] b, input logic [31:0] exp, input int exp_lat);
    issue(tag, op, a, b, exp, exp_lat);
    handshake(tag);
  endtask

  initial begin
    int seen;
    logic [31:0] held;
    rst_n = 1'b0; valid_i = 1'b0; kill_i = 1'b0; ready_i = 1'b1;
    operator_i = DIV_DIVU; op_a_i = '0; op_b_i = '0;
    #12;
    check_eq("rst_ready", 32'(ready_o), 32'd1);
    check_eq("rst_valid", 32'(valid_o), 32'd0);
    check_eq("rst_result", result_o, 32'd0);
    check_eq("rst_clz_en", 32'(alu_clz_en_o), 32'd0);
    check_eq("rst_sh_en", 32'(alu_shift_en_o), 32'd0);
    check_eq("rst_sh_amt", 32'(alu_shift_amt_o), 32'd0);
    check_eq("rst_op_a", alu_op_a_o, 32'd0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    run("divu_100_7", DIV_DIVU, 32'd100, 32'd7, 32'd14, 33);
    run("remu_100_7", DIV_REMU, 32'd100, 32'd7, 32'd2, 33);
    run("div_m7_2",   DIV_DIV,  32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 34);
    run("rem_m7_2",   DIV_REM,  32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 34);
    run("rem_7_m2",   DIV_REM,  32'd7, 32'hFFFFFFFE, 32'd1, 34);
    run("div_ovf",    DIV_DIV,  32'h80000000, 32'hFFFFFFFF, 32'h80000000, 35);
    run("rem_ovf",    DIV_REM,  32'h80000000, 32'hFFFFFFFF, 32'd0, 35);
    run("divu_z",     DIV_DIVU, 32'h1234, 32'd0, 32'hFFFFFFFF, 2);
    run("remu_z",     DIV_REMU, 32'h1234, 32'd0, 32'h1234, 2);
    run("div_m5_z",   DIV_DIV,  32'hFFFFFFFB, 32'd0, 32'hFFFFFFFF, 2);
    run("rem_m5_z",   DIV_REM,  32'hFFFFFFFB, 32'd0, 32'hFFFFFFFB, 2);
    run("divu_big",   DIV_DIVU, 32'hFFFFFFFF, 32'h00010000, 32'h0000FFFF, 19);

    // Kill in the third DIVIDE cycle (accept, CLZ, SHIFT, DIVIDE x3).
    operator_i = DIV_DIVU; op_a_i = 32'd100; op_b_i = 32'd7; valid_i = 1'b1;
    @(posedge clk); #1;
    valid_i = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check_eq("kill_pre_busy", 32'(ready_o), 32'd0);
    kill_i = 1'b1;
    @(posedge clk); #1;
    kill_i = 1'b0;
    check_eq("kill_idle", 32'(ready_o), 32'd1);
    check_eq("kill_clz_en", 32'(alu_clz_en_o), 32'd0);
    check_eq("kill_sh_en", 32'(alu_shift_en_o), 32'd0);
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      if (valid_o) seen++;
      @(posedge clk); #1;
    end
    check_eq("kill_no_valid", 32'(seen), 32'd0);
    run("divu_9_3", DIV_DIVU, 32'd9, 32'd3, 32'd3, 34);

    // Back-pressure: result held stable while the consumer stalls.
    ready_i = 1'b0;
    issue("stall", DIV_DIV, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 34);
    held = result_o;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check_eq("stall_valid", 32'(valid_o), 32'd1);
      check_eq("stall_res", result_o, 32'hFFFFFFFD);
      check_eq("stall_busy", 32'(ready_o), 32'd0);
    end
    check_eq("stall_held", result_o, held);
    handshake("stall");

    // Asynchronous reset in the middle of DIVIDE.
    operator_i = DIV_DIVU; op_a_i = 32'd100; op_b_i = 32'd7; valid_i = 1'b1;
    @(posedge clk); #1;
    valid_i = 1'b0;
    repeat (6) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check_eq("arst_ready", 32'(ready_o), 32'd1);
    check_eq("arst_valid", 32'(valid_o), 32'd0);
    check_eq("arst_result", result_o, 32'd0);
    check_eq("arst_clz_en", 32'(alu_clz_en_o), 32'd0);
    check_eq("arst_sh_amt", 32'(alu_shift_amt_o), 32'd0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    run("post_rst", DIV_REMU, 32'd100, 32'd7, 32'd2, 33);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
